pipelined_shift_unit: RTL and testbench

PIPELINED_SHIFT_UNIT -- requirements
Module: pipelined_shift_unit

---
 rtl/pipelined_shift_unit.sv | 161 ++++++++++++++++
 tb/tb_pipelined_shift_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shift_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pipelined_shift_unit: two-stage valid/ready barrel shifter (LSL/LSR/ASR/ROR/ROL).
// Optional macro SHIFT_FLAGS_EN adds registered OUT_CARRY/OUT_ZERO.  Rev 1.0
// ============================================================================
module pipelined_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] DATA,
  input  logic [AW-1:0]    AMT,
  input  logic [2:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             OUT_ERR
`ifdef SHIFT_FLAGS_EN
  ,
  output logic             OUT_CARRY,
  output logic             OUT_ZERO
`endif
);

  localparam int         LOG      = AW - 1;
  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [AW-1:0]    s1_amt;
  logic [2:0]       s1_mode;

  logic             adv;
  logic [LOG-1:0]   sh;
  logic             big;
  logic             msb;
  logic             r_rot;
  logic             r_fillbit;
  logic             l_rot;
  logic [WIDTH-1:0] shift_res;
  logic             shift_err;

  assign adv      = !OUT_VALID || OUT_READY;
  assign IN_READY = !s1_valid || adv;

  // Power-of-two WIDTH: the top AMT bit alone flags AMT >= WIDTH, and the
  // low bits are AMT modulo WIDTH for the rotates.
  assign sh        = s1_amt[LOG-1:0];
  assign big       = s1_amt[AW-1];
  assign msb       = s1_data[WIDTH-1];
  assign r_rot     = (s1_mode == MODE_ROR);
  assign r_fillbit = (s1_mode == MODE_ASR) & msb;
  assign l_rot     = (s1_mode == MODE_ROL);

  logic [LOG:0][WIDTH-1:0] rchain;
  logic [LOG:0][WIDTH-1:0] lchain;

  assign rchain[0] = s1_data;
  assign lchain[0] = s1_data;

  generate
    for (genvar k = 0; k < LOG; k++) begin : g_level
      localparam int S = 1 << k;
      logic [S-1:0] rfill;
      logic [S-1:0] lfill;
      assign rfill       = r_rot ? rchain[k][S-1:0] : {S{r_fillbit}};
      assign lfill       = l_rot ? lchain[k][WIDTH-1 -: S] : '0;
      assign rchain[k+1] = sh[k] ? {rfill, rchain[k][WIDTH-1:S]} : rchain[k];
      assign lchain[k+1] = sh[k] ? {lchain[k][WIDTH-S-1:0], lfill} : lchain[k];
    end
  endgenerate

  always_comb begin
    shift_res = s1_data;
    shift_err = 1'b0;
    case (s1_mode)
      MODE_LSL: shift_res = big ? '0 : lchain[LOG];
      MODE_LSR: shift_res = big ? '0 : rchain[LOG];
      MODE_ASR: shift_res = big ? {WIDTH{msb}} : rchain[LOG];
      MODE_ROR: shift_res = rchain[LOG];
      MODE_ROL: shift_res = lchain[LOG];
      default:  shift_err = 1'b1;
    endcase
  end

`ifdef SHIFT_FLAGS_EN
  logic           shift_carry;
  logic           amt_zero;
  logic           amt_eq_w;
  logic [LOG-1:0] idx_lsl;
  logic [LOG-1:0] idx_lsr;

  assign amt_zero = (s1_amt == '0);
  assign amt_eq_w = big && (sh == '0);
  // For 1 <= n < WIDTH: LSL loses DATA[WIDTH-n], right shifts lose DATA[n-1].
  assign idx_lsl  = LOG'(0) - sh;
  assign idx_lsr  = sh - LOG'(1);

  always_comb begin
    shift_carry = 1'b0;
    if (!amt_zero) begin
      case (s1_mode)
        MODE_LSL: shift_carry = big ? (amt_eq_w & s1_data[0]) : s1_data[idx_lsl];
        MODE_LSR: shift_carry = big ? (amt_eq_w & msb) : s1_data[idx_lsr];
        MODE_ASR: shift_carry = big ? msb : s1_data[idx_lsr];
        MODE_ROR: shift_carry = shift_res[WIDTH-1];
        MODE_ROL: shift_carry = shift_res[0];
        default:  shift_carry = 1'b0;
      endcase
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_amt    <= '0;
      s1_mode   <= '0;
      OUT_VALID <= 1'b0;
      RESULT    <= '0;
      OUT_ERR   <= 1'b0;
`ifdef SHIFT_FLAGS_EN
      OUT_CARRY <= 1'b0;
      OUT_ZERO  <= 1'b0;
`endif
    end else begin
      if (adv) begin
        OUT_VALID <= s1_valid;
        if (s1_valid) begin
          RESULT  <= shift_res;
          OUT_ERR <= shift_err;
`ifdef SHIFT_FLAGS_EN
          OUT_CARRY <= shift_carry;
          OUT_ZERO  <= (shift_res == '0);
`endif
        end
      end
      // IN_READY implies S1 is empty or moving on, so a simultaneous
      // accept and drain never overwrites a live request.
      if (IN_READY) begin
        s1_valid <= IN_VALID;
        if (IN_VALID) begin
          s1_data <= DATA;
          s1_amt  <= AMT;
          s1_mode <= MODE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_shift_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for pipelined_shift_unit (WIDTH=8); checks flags when SHIFT_FLAGS_EN is defined.
module tb_pipelined_shift_unit;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] amt;
    logic [2:0] mode;
    logic [7:0] res;
    logic       err;
    logic       carry;
    logic       zero;
  } vec_t;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
    logic       carry;
    logic       zero;
  } exp_t;

  logic       CLK;
  logic       RESET;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] DATA;
  logic [3:0] AMT;
  logic [2:0] MODE;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] RESULT;
  logic       OUT_ERR;
`ifdef SHIFT_FLAGS_EN
  logic       OUT_CARRY;
  logic       OUT_ZERO;
`endif

  pipelined_shift_unit #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .DATA      (DATA),
    .AMT       (AMT),
    .MODE      (MODE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .OUT_ERR   (OUT_ERR)
`ifdef SHIFT_FLAGS_EN
    ,
    .OUT_CARRY (OUT_CARRY),
    .OUT_ZERO  (OUT_ZERO)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  vec_t vecs [18];
  exp_t sb [$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   accepts = 0;
  bit   mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Present one request and hold it until accepted; the expected response is
  // queued at the moment of acceptance.
  task automatic send(input vec_t v, input bit need_ready);
    exp_t e;
    int   waits;
    bit   done;
    IN_VALID = 1'b1;
    DATA     = v.data;
    AMT      = v.amt;
    MODE     = v.mode;
    waits    = 0;
    done     = 1'b0;
    while (!done) begin
      #1;
      if (need_ready && waits == 0) chk("in_ready_no_stall", 64'(IN_READY), 64'(1));
      if (IN_READY) begin
        e.res   = v.res;
        e.err   = v.err;
        e.carry = v.carry;
        e.zero  = v.zero;
        sb.push_back(e);
        accepts++;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 50) begin
          n_cmp++;
          n_fail++;
          $display("FAIL send_timeout: IN_READY stuck at %0d, required 1", IN_READY);
          done = 1'b1;
        end
      end
      @(negedge CLK);
    end
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || OUT_VALID) && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: every presented result is compared with the queue head (so a
  // stalled output must hold its value), and popped when it is taken.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (mon_en && !RESET && OUT_VALID) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stale_output: OUT_VALID 1 with RESULT %0h, required no output", RESULT);
        end else begin
          chk("result", 64'(RESULT), 64'(sb[0].res));
          chk("out_err", 64'(OUT_ERR), 64'(sb[0].err));
`ifdef SHIFT_FLAGS_EN
          chk("out_carry", 64'(OUT_CARRY), 64'(sb[0].carry));
          chk("out_zero", 64'(OUT_ZERO), 64'(sb[0].zero));
`endif
          if (OUT_READY) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            data   amt    mode    result err carry zero
    vecs[0]  = '{8'h81, 4'd1,  3'b000, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{8'h90, 4'd9,  3'b010, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{8'h90, 4'd9,  3'b001, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'hA5, 4'd8,  3'b011, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'hA5, 4'd3,  3'b011, 8'hB4, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'h3C, 4'd2,  3'b110, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h96, 4'd0,  3'b000, 8'h96, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h96, 4'd3,  3'b001, 8'h12, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h96, 4'd2,  3'b010, 8'hE5, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h96, 4'd3,  3'b100, 8'hB4, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'h97, 4'd8,  3'b000, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{8'h97, 4'd8,  3'b001, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{8'h40, 4'd15, 3'b010, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'h01, 4'd12, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'h81, 4'd4,  3'b000, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{8'h5A, 4'd7,  3'b111, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{8'hC3, 4'd9,  3'b100, 8'h87, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{8'h01, 4'd1,  3'b011, 8'h80, 1'b0, 1'b1, 1'b0};

    RESET     = 1'b1;
    IN_VALID  = 1'b0;
    DATA      = '0;
    AMT       = '0;
    MODE      = '0;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    RESET  = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("reset_out_valid", 64'(OUT_VALID), 64'(0));
    chk("reset_in_ready", 64'(IN_READY), 64'(1));
    chk("reset_result", 64'(RESULT), 64'(0));
    chk("reset_out_err", 64'(OUT_ERR), 64'(0));
`ifdef SHIFT_FLAGS_EN
    chk("reset_out_carry", 64'(OUT_CARRY), 64'(0));
    chk("reset_out_zero", 64'(OUT_ZERO), 64'(0));
`endif
    @(negedge CLK);

    // Two-cycle latency on an idle pipeline.
    send(vecs[0], 1'b1);
    IN_VALID = 1'b0;
    #1;
    chk("latency_cycle1_out_valid", 64'(OUT_VALID), 64'(0));
    @(negedge CLK);
    #1;
    chk("latency_cycle2_out_valid", 64'(OUT_VALID), 64'(1));
    @(negedge CLK);

    // Back-to-back stream at full throughput.
    for (int i = 1; i < 18; i++) send(vecs[i], 1'b1);
    IN_VALID = 1'b0;
    drain();

    // Backpressure: consumer stalls for 5 cycles under 4 queued requests.
    OUT_READY = 1'b0;
    accepts   = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i + 6], 1'b0);
        IN_VALID = 1'b0;
      end
      begin
        repeat (5) @(negedge CLK);
        chk("stall_accepts", 64'(accepts), 64'(2));
        chk("stall_in_ready", 64'(IN_READY), 64'(0));
        OUT_READY = 1'b1;
      end
    join
    drain();

    // Reset with both stages full; the request shown during reset is ignored.
    OUT_READY = 1'b0;
    send(vecs[4], 1'b0);
    send(vecs[5], 1'b0);
    RESET     = 1'b1;
    IN_VALID  = 1'b1;
    DATA      = vecs[16].data;
    AMT       = vecs[16].amt;
    MODE      = vecs[16].mode;
    OUT_READY = 1'b1;
    sb.delete();
    @(negedge CLK);
    RESET    = 1'b0;
    IN_VALID = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(OUT_VALID), 64'(0));
    chk("midreset_in_ready", 64'(IN_READY), 64'(1));
    chk("midreset_result", 64'(RESULT), 64'(0));
    repeat (6) @(negedge CLK);

    send(vecs[17], 1'b1);
    IN_VALID = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
